// File: rtl/wb_queue.sv
// Write-back queue: buffers ALU and load results in order, drains one per cycle
// into the register file write port, and offers two forwarding lookups.
// Optional stall statistics counter is enabled by defining WBQ_STATS_EN.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_valid_i,
    input  logic [AW-1:0]              alu_addr_i,
    input  logic [DW-1:0]              alu_data_i,
    output logic                       alu_ready_o,
    input  logic                       mem_valid_i,
    input  logic [AW-1:0]              mem_addr_i,
    input  logic [DW-1:0]              mem_data_i,
    output logic                       mem_ready_o,
    output logic [AW-1:0]              RDaddr_o,
    output logic [DW-1:0]              RDdata_o,
    output logic                       RegWrite_o,
    input  logic [AW-1:0]              RSaddr_i,
    output logic [DW-1:0]              RSdata_o,
    output logic                       RS_hit_o,
    input  logic [AW-1:0]              RTaddr_i,
    output logic [DW-1:0]              RTdata_o,
    output logic                       RT_hit_o,
`ifdef WBQ_STATS_EN
    output logic [15:0]                stall_cnt_o,
`endif
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] mem_slot;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          alu_push;
    logic          mem_push;
    logic          pop;

    // Free space ignores this cycle's pop, so readiness never depends on the drain.
    assign free        = CW'(DEPTH) - count;
    assign alu_ready_o = !rst_i && (free >= CW'(1));
    assign mem_ready_o = !rst_i && (alu_valid_i ? (free >= CW'(2)) : (free >= CW'(1)));

    // Writes to r0 complete the handshake but are dropped here.
    assign alu_push = alu_valid_i && alu_ready_o && (alu_addr_i != '0);
    assign mem_push = mem_valid_i && mem_ready_o && (mem_addr_i != '0);
    assign pop      = (count != '0);
    assign mem_slot = wr_ptr + PW'(alu_push);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + CW'(alu_push) + CW'(mem_push) - CW'(pop);
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(alu_push) + PW'(mem_push);
        end
    end

    always_ff @(posedge clk_i) begin
        if (alu_push) begin
            addr_q[wr_ptr] <= alu_addr_i;
            data_q[wr_ptr] <= alu_data_i;
        end
        if (mem_push) begin
            addr_q[mem_slot] <= mem_addr_i;
            data_q[mem_slot] <= mem_data_i;
        end
    end

    // Write enable is masked during reset so discarded entries never reach the register file.
    assign RegWrite_o = (count != '0) && !rst_i;
    assign RDaddr_o   = (count != '0) ? addr_q[rd_ptr] : '0;
    assign RDdata_o   = (count != '0) ? data_q[rd_ptr] : '0;
    assign count_o    = count;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        RS_hit_o = 1'b0;
        RSdata_o = '0;
        RT_hit_o = 1'b0;
        RTdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if ((RSaddr_i != '0) && (addr_q[idx] == RSaddr_i)) begin
                    RS_hit_o = 1'b1;
                    RSdata_o = data_q[idx];
                end
                if ((RTaddr_i != '0) && (addr_q[idx] == RTaddr_i)) begin
                    RT_hit_o = 1'b1;
                    RTdata_o = data_q[idx];
                end
            end
        end
    end

`ifdef WBQ_STATS_EN
    logic stall;
    assign stall = (alu_valid_i & ~alu_ready_o) | (mem_valid_i & ~mem_ready_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: stimulus pushes expected writes, a monitor
// pops and compares them whenever the register file write port is enabled.
module tb_wb_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write;
    logic [4:0]  rs_addr = '0;
    logic [31:0] rs_data;
    logic        rs_hit;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rt_data;
    logic        rt_hit;
    logic [2:0]  count;
`ifdef WBQ_STATS_EN
    logic [15:0] stall_cnt;
`endif

    wr_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  model_count = 0;
    int  model_stall = 0;

    wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .alu_valid_i (alu_valid),
        .alu_addr_i  (alu_addr),
        .alu_data_i  (alu_data),
        .alu_ready_o (alu_ready),
        .mem_valid_i (mem_valid),
        .mem_addr_i  (mem_addr),
        .mem_data_i  (mem_data),
        .mem_ready_o (mem_ready),
        .RDaddr_o    (rd_addr),
        .RDdata_o    (rd_data),
        .RegWrite_o  (reg_write),
        .RSaddr_i    (rs_addr),
        .RSdata_o    (rs_data),
        .RS_hit_o    (rs_hit),
        .RTaddr_i    (rt_addr),
        .RTdata_o    (rt_data),
        .RT_hit_o    (rt_hit),
`ifdef WBQ_STATS_EN
        .stall_cnt_o (stall_cnt),
`endif
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every enabled write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && reg_write === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected write: got r%0d=0x%0h, expected no write", rd_addr, rd_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check_output("wb addr", 32'(rd_addr), 32'(e.addr));
                check_output("wb data", rd_data, e.data);
            end
        end
    end

    // One clock of stimulus; the bench's own occupancy model predicts readiness and acceptance.
    task automatic apply_stimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                  input logic mv, input logic [4:0] ma, input logic [31:0] md);
        int  free;
        int  pushes;
        logic exp_ar;
        logic exp_mr;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        free   = DEPTH - model_count;
        exp_ar = (free >= 1);
        exp_mr = av ? (free >= 2) : (free >= 1);
        @(negedge clk);
        check_output("alu_ready", 32'(alu_ready), 32'(exp_ar));
        check_output("mem_ready", 32'(mem_ready), 32'(exp_mr));
        check_output("count", 32'(count), 32'(model_count));
        check_output("reg_write", 32'(reg_write), 32'(model_count != 0));
        @(posedge clk);
        pushes = 0;
        if (av && exp_ar && aa != 5'd0) begin
            sb.push_back('{addr: aa, data: ad});
            pushes++;
        end
        if (mv && exp_mr && ma != 5'd0) begin
            sb.push_back('{addr: ma, data: md});
            pushes++;
        end
        if ((av && !exp_ar) || (mv && !exp_mr)) model_stall++;
        model_count = model_count + pushes - ((model_count != 0) ? 1 : 0);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h44;
        sb.delete();
        #1;
        check_output("rst reg_write", 32'(reg_write), 32'd0);
        check_output("rst alu_ready", 32'(alu_ready), 32'd0);
        check_output("rst mem_ready", 32'(mem_ready), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_output("rst alu_ready", 32'(alu_ready), 32'd0);
            check_output("rst mem_ready", 32'(mem_ready), 32'd0);
            check_output("rst reg_write", 32'(reg_write), 32'd0);
            check_output("rst count", 32'(count), 32'd0);
            check_output("rst rs_hit", 32'(rs_hit), 32'd0);
            check_output("rst rt_hit", 32'(rt_hit), 32'd0);
        end
        model_count = 0;
        model_stall = 0;
        rst = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] wb_queue bench start");
        do_reset(2);
`ifdef WBQ_STATS_EN
        check_output("stall after reset", 32'(stall_cnt), 32'd0);
`endif
        idle(2);

        // Single ALU push
        apply_stimulus(1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
        check_output("t2 count", 32'(count), 32'd1);
        check_output("t2 reg_write", 32'(reg_write), 32'd1);
        check_output("t2 rd_addr", 32'(rd_addr), 32'd8);
        check_output("t2 rd_data", rd_data, 32'h0000_1234);
        idle(1);
        check_output("t2 drained", 32'(reg_write), 32'd0);
        check_output("t2 count0", 32'(count), 32'd0);
        check_output("t2 empty addr", 32'(rd_addr), 32'd0);

        // Simultaneous push: ALU entry is older
        apply_stimulus(1'b1, 5'd9, 32'hA, 1'b1, 5'd10, 32'hB);
        check_output("t3 count", 32'(count), 32'd2);
        check_output("t3 first addr", 32'(rd_addr), 32'd9);
        check_output("t3 first data", rd_data, 32'hA);
        idle(1);
        check_output("t3 second addr", 32'(rd_addr), 32'd10);
        check_output("t3 second data", rd_data, 32'hB);
        idle(2);

        // Continuous dual pushes; occupancy settles at 3 with the memory side throttled
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(i + 17), 32'h200 + 32'(i));
        check_output("t4 steady count", 32'(count), 32'd3);
        idle(5);
`ifdef WBQ_STATS_EN
        check_output("t4 stall_cnt", 32'(stall_cnt), 32'(model_stall));
`endif

        // Register 0 writes are accepted and dropped
        apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
        check_output("t5 count", 32'(count), 32'd0);
        check_output("t5 reg_write", 32'(reg_write), 32'd0);
        apply_stimulus(1'b1, 5'd0, 32'h77, 1'b1, 5'd12, 32'hC0DE);
        check_output("t5 mixed count", 32'(count), 32'd1);
        idle(2);

        // Forwarding: youngest match wins, incoming requests are not searched
        rs_addr = 5'd5;
        rt_addr = 5'd6;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'd1;
        mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'd2;
        #1;
        check_output("t6 incoming rs_hit", 32'(rs_hit), 32'd0);
        apply_stimulus(1'b1, 5'd5, 32'd1, 1'b1, 5'd5, 32'd2);
        check_output("t6 rs_hit", 32'(rs_hit), 32'd1);
        check_output("t6 rs_data", rs_data, 32'd2);
        check_output("t6 rt_hit", 32'(rt_hit), 32'd0);
        check_output("t6 rt_data", rt_data, 32'd0);
        rs_addr = 5'd0;
        #1;
        check_output("t6 r0 lookup hit", 32'(rs_hit), 32'd0);
        rs_addr = 5'd5;
        idle(1);
        check_output("t6 after drain hit", 32'(rs_hit), 32'd1);
        check_output("t6 after drain data", rs_data, 32'd2);
        idle(1);
        check_output("t6 empty hit", 32'(rs_hit), 32'd0);
        check_output("t6 empty data", rs_data, 32'd0);

        // Reset with entries pending must write none of them
        apply_stimulus(1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd21, 32'hBEEF);
        do_reset(1);
        idle(3);
        check_output("mid reset count", 32'(count), 32'd0);

        idle(2);
        check_output("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
